// File: rtl/sram_burst_address_gen_if.sv
// Bus bundle between the SPI transfer controller and the SRAM burst address generator.
`default_nettype none

interface sram_burst_address_gen_if #(
  parameter int ADDR_W = 13,
  parameter int LEN_W  = 8
);
  logic              initR;
  logic              load;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  burst_len;
  logic              dir;
  logic              wrap;
  logic              incR;
  logic [ADDR_W-1:0] address;
  logic              busy;
  logic              last;
  logic              done;
  logic              ovf;

  modport master (
    output initR, load, start_addr, burst_len, dir, wrap, incR,
    input  address, busy, last, done, ovf
  );

  modport slave (
    input  initR, load, start_addr, burst_len, dir, wrap, incR,
    output address, busy, last, done, ovf
  );
endinterface

`default_nettype wire

// File: rtl/sram_burst_address_gen.sv
`default_nettype none
// ============================================================================
// Module   : sram_burst_address_gen
// Purpose  : SRAM burst address generator (up/down stepping, beat count,
//            busy/last/done). Optional aligned-window wrap: SRAM_ADDR_WRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================

module sram_burst_address_gen #(
  parameter int ADDR_W    = 13,
  parameter int LEN_W     = 8,
  parameter int STEP      = 1,
  parameter int WRAP_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  sram_burst_address_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] c_step = (ADDR_W + 1)'(STEP);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [LEN_W-1:0]  r_rem, w_rem_nxt;
  logic              r_dir, w_dir_nxt;
  logic              r_ovf, w_ovf_nxt;

  // Linear step carries one extra bit so the carry/borrow flags overflow.
  logic [ADDR_W:0]   w_sum_up, w_sum_dn;
  logic [ADDR_W-1:0] w_lin_addr, w_burst_addr;
  logic              w_lin_ovf, w_burst_ovf;

  assign w_sum_up   = {1'b0, r_addr} + c_step;
  assign w_sum_dn   = {1'b0, r_addr} - c_step;
  assign w_lin_addr = r_dir ? w_sum_dn[ADDR_W-1:0] : w_sum_up[ADDR_W-1:0];
  assign w_lin_ovf  = r_dir ? w_sum_dn[ADDR_W]     : w_sum_up[ADDR_W];

`ifdef SRAM_ADDR_WRAP_EN
  localparam logic [WRAP_LOG2-1:0] c_step_win = WRAP_LOG2'(STEP);

  logic                 r_wrap, w_wrap_nxt;
  logic [WRAP_LOG2-1:0] w_win_low;

  assign w_win_low    = r_dir ? (r_addr[WRAP_LOG2-1:0] - c_step_win)
                              : (r_addr[WRAP_LOG2-1:0] + c_step_win);
  assign w_burst_addr = r_wrap ? {r_addr[ADDR_W-1:WRAP_LOG2], w_win_low} : w_lin_addr;
  assign w_burst_ovf  = r_wrap ? 1'b0 : w_lin_ovf;
  assign w_wrap_nxt   = bus.load ? bus.wrap : r_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrap <= 1'b0;
    end else if (!bus.initR) begin
      r_wrap <= w_wrap_nxt;
    end
  end
`else
  // Wrap request and window size have no effect in the linear-only build.
  logic unused_wrap;
  assign unused_wrap  = ^{bus.wrap, 32'(WRAP_LOG2)};
  assign w_burst_addr = w_lin_addr;
  assign w_burst_ovf  = w_lin_ovf;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_rem   <= w_rem_nxt;
      r_dir   <= w_dir_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_rem_nxt   = r_rem;
    w_dir_nxt   = r_dir;
    w_ovf_nxt   = r_ovf;

    if (bus.load) begin
      // A load restarts from any state; an aborted burst never reports done.
      w_addr_nxt  = bus.start_addr;
      w_rem_nxt   = bus.burst_len;
      w_dir_nxt   = bus.dir;
      w_ovf_nxt   = 1'b0;
      w_state_nxt = (bus.burst_len == '0) ? ST_DONE : ST_BURST;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.incR) begin
            w_addr_nxt = w_lin_addr;
            w_ovf_nxt  = r_ovf | w_lin_ovf;
          end
        end
        ST_BURST: begin
          if (bus.incR) begin
            w_addr_nxt = w_burst_addr;
            w_ovf_nxt  = r_ovf | w_burst_ovf;
            w_rem_nxt  = r_rem - LEN_W'(1);
            if (r_rem == LEN_W'(1)) begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    if (bus.initR) begin
      w_addr_nxt  = '0;
      w_rem_nxt   = '0;
      w_ovf_nxt   = 1'b0;
      w_dir_nxt   = r_dir;
      w_state_nxt = ST_IDLE;
    end
  end

  assign bus.address = r_addr;
  assign bus.busy    = (r_state == ST_BURST);
  assign bus.done    = (r_state == ST_DONE);
  assign bus.last    = (r_state == ST_BURST) && (r_rem == LEN_W'(1));
  assign bus.ovf     = r_ovf;

endmodule

`default_nettype wire
